instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, the number of cycles ALU operands are held before writeback; legal range 1..15.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port instr_valid  in  1  instruction offered.
REQ-005 SHALL have port instr  in  24  instruction: [23:16] ALU op byte or immediate high, [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2 (or [7:0] immediate low).
REQ-006 SHALL have port instr_ready  out  1  sequencer can accept an instruction.
REQ-007 SHALL have port initialR  out  16  immediate value driven onto the write bus.
REQ-008 SHALL have ports regWrite, regRead1 and regRead2, each  out  4, which are the register write select and the two read selects.
REQ-009 SHALL have port ALUOp  out  8  ALU operation.
REQ-010 SHALL have port buffCtrl  out  4  bus buffer enables: [0] immediate to write bus, [1] A bus, [2] B bus, [3] ALU result to write bus.
REQ-011 SHALL have port regWriteEn  out  1  register file write enable.
REQ-012 SHALL have ports busy, halted and err_illegal, each  out  1; retired  out  16  count of completed instructions.

Function
REQ-013 SHALL implement states IDLE, DECODE, EXEC, WB, WRITE_IMM and HALTED.
REQ-014 instr_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state except IDLE and HALTED.
REQ-015 IDLE: on instr_valid and instr_ready at a rising edge, SHALL latch instr and enter DECODE; without valid, SHALL stay in IDLE.
REQ-016 DECODE, opcode 0x0 (NOP): one cycle, retire, then IDLE.
REQ-017 DECODE, opcode 0x1 (LOADI): SHALL go to WRITE_IMM.
REQ-018 DECODE, opcode 0x2 (ALU): SHALL go to EXEC.
REQ-019 DECODE, opcode 0xF (HALT): SHALL go to HALTED without retiring.
REQ-020 DECODE, any other opcode: SHALL set sticky err_illegal, retire as a NOP, then go to IDLE.
REQ-021 WRITE_IMM: one cycle with initialR={instr[23:16],instr[7:0]}, buffCtrl=4'b0001, regWrite=rd, regWriteEn=1; then retire and go to IDLE.
REQ-022 EXEC: for exactly EXEC_CYCLES cycles, regRead1=rs1, regRead2=rs2, ALUOp=instr[23:16], buffCtrl=4'b0110, regWriteEn=0.
REQ-023 WB: one cycle holding the EXEC selects, with buffCtrl=4'b1110, regWrite=rd, regWriteEn=1; then retire and go to IDLE.
REQ-024 Latency: for a handshake at edge t, the LOADI write SHALL occur in cycle t+2 with ready in t+3; the ALU writeback SHALL occur in t+2+EXEC_CYCLES with ready in t+3+EXEC_CYCLES.
REQ-025 buffCtrl[0] and buffCtrl[3] SHALL never be 1 in the same cycle (write bus contention).
REQ-026 regWriteEn SHALL be 1 only in WRITE_IMM and WB.
REQ-027 In IDLE, DECODE and HALTED, buffCtrl, regWriteEn and initialR SHALL be 0.
REQ-028 retired SHALL increment by 1 on each retire and SHALL wrap from 0xFFFF to 0x0000.
REQ-029 HALTED SHALL be held until reset, with halted=1, instr_ready=0 and instr_valid ignored.
REQ-030 instr SHALL be sampled only at the handshake; changes to instr while busy SHALL have no effect.
REQ-031 rd equal to rs1 or rs2 SHALL be legal; the write SHALL occur only in WB.

Reset
REQ-032 reset SHALL immediately force IDLE; all outputs SHALL be 0 except instr_ready=1; retired=0; err_illegal=0.
REQ-033 reset asserted mid-EXEC or mid-WB SHALL abort the instruction with no further regWriteEn and no retire.
REQ-034 The first handshake SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-035 LOADI rd=3, imm=0x1234, valid held: regWriteEn=1 with regWrite=3, initialR=0x1234 and buffCtrl=0001 in t+2; ready in t+3; retired=1.
REQ-036 ALU rs1=1, rs2=2, rd=4, op=0x05, EXEC_CYCLES=3: buffCtrl=0110 for 3 cycles, then WB with buffCtrl=1110, regWrite=4, ALUOp=0x05 at t+5.
REQ-037 Opcode 0x7: err_illegal=1 stays set, retired increments, no regWriteEn.
REQ-038 HALT then instr_valid=1 for 10 cycles: halted=1, instr_ready=0, retired unchanged; reset then restores IDLE.
REQ-039 reset pulse during EXEC: outputs zero asynchronously, no write, retired unchanged.
REQ-040 Preload retired=0xFFFF via 65535 NOPs, then one more NOP: retired=0x0000; buffCtrl[0]&buffCtrl[3] never 1 throughout (assertion).

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: accepts one 24-bit instruction at a time and steps the
// register-file / ALU / bus-buffer controls through decode, execute and writeback.
module instr_sequencer #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [23:0] instr,
    output logic        instr_ready,
    output logic [15:0] initialR,
    output logic [3:0]  regWrite,
    output logic [3:0]  regRead1,
    output logic [3:0]  regRead2,
    output logic [7:0]  ALUOp,
    output logic [3:0]  buffCtrl,
    output logic        regWriteEn,
    output logic        busy,
    output logic        halted,
    output logic        err_illegal,
    output logic [15:0] retired,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXEC      = 3'd2,
        S_WB        = 3'd3,
        S_WRITE_IMM = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOADI = 4'h1;
    localparam logic [3:0] OP_ALU   = 4'h2;
    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    state_t      state_q, state_d;
    logic [23:0] instr_q;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q;
    logic [15:0] retired_q;
    logic        accept;
    logic        retire;
    logic        set_err;

    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [7:0]  op_byte;
    logic [15:0] imm;

    // Every field decodes from the latched copy, so instr may change freely while busy.
    assign opcode  = instr_q[15:12];
    assign rd      = instr_q[11:8];
    assign rs1     = instr_q[7:4];
    assign rs2     = instr_q[3:0];
    assign op_byte = instr_q[23:16];
    assign imm     = {instr_q[23:16], instr_q[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            instr_q   <= 24'd0;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                instr_q <= instr;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (retire) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        retire      = 1'b0;
        set_err     = 1'b0;
        instr_ready = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        initialR    = 16'd0;
        regWrite    = 4'd0;
        regRead1    = 4'd0;
        regRead2    = 4'd0;
        ALUOp       = 8'd0;
        buffCtrl    = 4'b0000;
        regWriteEn  = 1'b0;

        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                busy = 1'b1;
                case (opcode)
                    OP_NOP: begin
                        retire  = 1'b1;
                        state_d = S_IDLE;
                    end
                    OP_LOADI: state_d = S_WRITE_IMM;
                    OP_ALU: begin
                        cnt_d   = 4'd0;
                        state_d = S_EXEC;
                    end
                    OP_HALT: state_d = S_HALTED;
                    default: begin
                        set_err = 1'b1;
                        retire  = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_EXEC: begin
                busy     = 1'b1;
                regRead1 = rs1;
                regRead2 = rs2;
                ALUOp    = op_byte;
                buffCtrl = 4'b0110;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WB: begin
                // ALU result drives the write bus; the immediate buffer stays off.
                busy       = 1'b1;
                regRead1   = rs1;
                regRead2   = rs2;
                ALUOp      = op_byte;
                buffCtrl   = 4'b1110;
                regWrite   = rd;
                regWriteEn = 1'b1;
                retire     = 1'b1;
                state_d    = S_IDLE;
            end
            S_WRITE_IMM: begin
                busy       = 1'b1;
                initialR   = imm;
                buffCtrl   = 4'b0001;
                regWrite   = rd;
                regWriteEn = 1'b1;
                retire     = 1'b1;
                state_d    = S_IDLE;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign err_illegal = err_q;
    assign retired     = retired_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: a per-instruction timeline model predicts
// every output on every cycle after each handshake.
module tb_instr_sequencer;

    localparam int E = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [23:0] instr;
    logic        instr_ready;
    logic [15:0] initialR;
    logic [3:0]  regWrite;
    logic [3:0]  regRead1;
    logic [3:0]  regRead2;
    logic [7:0]  ALUOp;
    logic [3:0]  buffCtrl;
    logic        regWriteEn;
    logic        busy;
    logic        halted;
    logic        err_illegal;
    logic [15:0] retired;
    logic [2:0]  dbg_state;

    int          n_tests = 0;
    int          n_fail = 0;
    int          n_contend = 0;
    logic [15:0] m_ret;
    logic        m_err;
    logic [63:0] exp_q[$];
    logic [63:0] reset_vec;

    instr_sequencer #(.EXEC_CYCLES(E)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .initialR(initialR), .regWrite(regWrite),
        .regRead1(regRead1), .regRead2(regRead2), .ALUOp(ALUOp),
        .buffCtrl(buffCtrl), .regWriteEn(regWriteEn), .busy(busy),
        .halted(halted), .err_illegal(err_illegal), .retired(retired),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    wire [63:0] obs = {3'b000, instr_ready, busy, halted, err_illegal, regWriteEn, buffCtrl,
                       regWrite, regRead1, regRead2, ALUOp, initialR, retired};

    always @(negedge clk) begin
        if (buffCtrl[0] && buffCtrl[3]) n_contend++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic rdy, input logic bsy, input logic hlt,
                                         input logic err, input logic we, input logic [3:0] bc,
                                         input logic [3:0] rw, input logic [3:0] r1,
                                         input logic [3:0] r2, input logic [7:0] op,
                                         input logic [15:0] imm, input logic [15:0] ret);
        return {3'b000, rdy, bsy, hlt, err, we, bc, rw, r1, r2, op, imm, ret};
    endfunction

    function automatic int len_of(input logic [3:0] opc);
        case (opc)
            4'h1:    return 3;
            4'h2:    return 3 + E;
            4'hF:    return 12;
            default: return 2;
        endcase
    endfunction

    // Expected outputs k cycles after the handshake edge (k=1 is the first cycle after it).
    function automatic logic [63:0] exp_at(input logic [23:0] w, input int k);
        logic [3:0]  opc;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
        logic        illegal;
        opc     = w[15:12];
        rd      = w[11:8];
        rs1     = w[7:4];
        rs2     = w[3:0];
        imm     = {w[23:16], w[7:0]};
        illegal = !(opc inside {4'h0, 4'h1, 4'h2, 4'hF});
        if (opc != 4'hF && k >= len_of(opc))
            return pack(1, 0, 0, m_err | illegal, 0, 4'b0000, 4'd0, 4'd0, 4'd0, 8'd0, 16'd0, m_ret + 16'd1);
        if (k == 1)
            return pack(0, 1, 0, m_err, 0, 4'b0000, 4'd0, 4'd0, 4'd0, 8'd0, 16'd0, m_ret);
        if (opc == 4'hF)
            return pack(0, 0, 1, m_err, 0, 4'b0000, 4'd0, 4'd0, 4'd0, 8'd0, 16'd0, m_ret);
        if (opc == 4'h1)
            return pack(0, 1, 0, m_err, 1, 4'b0001, rd, 4'd0, 4'd0, 8'd0, imm, m_ret);
        if (k < 2 + E)
            return pack(0, 1, 0, m_err, 0, 4'b0110, 4'd0, rs1, rs2, w[23:16], 16'd0, m_ret);
        return pack(0, 1, 0, m_err, 1, 4'b1110, rd, rs1, rs2, w[23:16], 16'd0, m_ret);
    endfunction

    // Called just after a falling edge with the DUT idle; returns on a falling edge.
    task automatic run_instr(input logic [23:0] w, input bit hold);
        logic [3:0] opc;
        int         len;
        opc = w[15:12];
        len = len_of(opc);
        for (int k = 1; k <= len; k++) exp_q.push_back(exp_at(w, k));
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        if (opc == 4'hF) begin
            instr_valid = 1'b1;
            instr       = {8'h00, 4'h1, 4'h5, 8'hAA};
        end else if (!hold) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr       = 24'($urandom);
        end
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            check($sformatf("op%h_k%0d", opc, k), obs, exp_q.pop_front());
        end
        if (opc != 4'hF) begin
            m_ret = m_ret + 16'd1;
            if (!(opc inside {4'h0, 4'h1, 4'h2})) m_err = 1'b1;
            instr_valid = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            instr = 24'($urandom);
            @(negedge clk);
            check("idle", obs, pack(1, 0, 0, m_err, 0, 4'b0000, 4'd0, 4'd0, 4'd0, 8'd0, 16'd0, m_ret));
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        instr_valid = 1'b0;
        #1;
        check("rst_async", obs, reset_vec);
        @(negedge clk);
        check("rst_hold", obs, reset_vec);
        reset = 1'b0;
        m_ret = 16'd0;
        m_err = 1'b0;
    endtask

    initial begin
        logic [23:0] w;
        logic [3:0]  opc;
        reset_vec   = pack(1, 0, 0, 0, 0, 4'b0000, 4'd0, 4'd0, 4'd0, 8'd0, 16'd0, 16'd0);
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 24'd0;
        m_ret       = 16'd0;
        m_err       = 1'b0;
        #1;
        check("por", obs, reset_vec);
        @(negedge clk);
        reset = 1'b0;

        // LOADI rd=3 imm=0x1234 with valid and instr held, accepted on the first edge.
        run_instr({8'h12, 4'h1, 4'h3, 8'h34}, 1'b1);
        // ALU rd=4 rs1=1 rs2=2 op=0x05.
        run_instr({8'h05, 4'h2, 4'h4, 4'h1, 4'h2}, 1'b0);
        // Illegal opcode 0x7, then a LOADI to show err stays set.
        run_instr({8'hA5, 4'h7, 4'h9, 8'h3C}, 1'b0);
        run_instr({8'hBE, 4'h1, 4'hF, 8'hEF}, 1'b0);
        idle_cycles(2);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    opc = 4'h0;
                2, 3, 4: opc = 4'h1;
                5, 6, 7: opc = 4'h2;
                8:       opc = 4'($urandom_range(3, 14));
                default: opc = 4'hE;
            endcase
            if (opc == 4'hE && i[0]) begin
                idle_cycles($urandom_range(1, 3));
            end else begin
                w = {8'($urandom), opc, 12'($urandom)};
                run_instr(w, 1'($urandom_range(0, 1)));
            end
        end

        // Reset pulse in the middle of EXEC aborts the ALU op without a retire.
        do_reset();
        instr       = {8'h33, 4'h2, 4'h1, 4'h1, 4'h1};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        check("abort_dec", obs, pack(0, 1, 0, 0, 0, 4'b0000, 4'd0, 4'd0, 4'd0, 8'd0, 16'd0, 16'd0));
        @(negedge clk);
        check("abort_exec", obs, pack(0, 1, 0, 0, 0, 4'b0110, 4'd0, 4'd1, 4'd1, 8'h33, 16'd0, 16'd0));
        #2;
        reset = 1'b1;
        #1;
        check("abort_async", obs, reset_vec);
        @(posedge clk);
        #1;
        check("abort_hold", obs, reset_vec);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(E + 2);
        run_instr({8'h00, 4'h0, 12'h000}, 1'b0);

        // HALT ignores valid until reset.
        run_instr({8'h00, 4'hF, 12'h000}, 1'b0);
        do_reset();
        idle_cycles(1);
        run_instr({8'h56, 4'h1, 4'h2, 8'h78}, 1'b0);

        // Counter wrap: preload near the top, then three NOPs step through 0xFFFF to 0.
        dut.retired_q = 16'hFFFD;
        m_ret = 16'hFFFD;
        for (int i = 0; i < 3; i++) run_instr({8'($urandom), 4'h0, 12'($urandom)}, 1'b0);
        check("wrap", {48'd0, retired}, 64'd0);
        check("contention", 64'(n_contend), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
